prog_loader: RTL and testbench
==============================

# prog_loader

Synthesizable program/data loader and run controller for the rv32i_sc core, replacing hand-sequenced BRAM initialisation and PC-stall control. It accepts a framed 32-bit word stream (valid/ready), writes words into one of `NUM_MEMS` BRAM write ports (instruction BRAM = 0, data BRAM = 1 by default), then releases the core's PC stall for a programmed number of cycles. It sits between the host link (UART/JTAG bridge or testbench) and the `pc` / `bram32` write ports.

## Interface
- `DATA_WIDTH`, 32, stream and BRAM word width
- `ADDR_WIDTH`, 10, BRAM byte-address width
- `NUM_MEMS`, 2, number of target BRAM write ports
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset; synchronous, active-high
- `s_valid`  in  1  stream word valid
- `s_data`  in  DATA_WIDTH  stream word
- `s_ready`  out  1  loader accepts word when `s_valid && s_ready`
- `halt_req`  in  1  ends a RUN early
- `w_addr`  out  NUM_MEMS*ADDR_WIDTH  per-memory write byte address, packed, mem 0 in LSBs
- `w_dat`  out  NUM_MEMS*DATA_WIDTH  per-memory write data, packed
- `w_enb`  out  NUM_MEMS  per-memory write enable, at most one bit high
- `cpu_stall`  out  1  drives `pc.stall`
- `busy`  out  1  state != IDLE
- `load_done`  out  1  one-cycle pulse after last data word written
- `run_done`  out  1  one-cycle pulse when RUN ends
- `err`  out  1  sticky bad-header flag, cleared only by `rst`

## Operation
- Header word: `[31:24]` cmd, `[23:16]` mem select, `[15:0]` count.
- cmd 0x01 LOAD: next word is base byte address (low ADDR_WIDTH bits used), then `count` data words. Word i written to `base + 4*i`, modulo 2^ADDR_WIDTH (wrap silently).
- cmd 0x02 RUN: `cpu_stall`=0 for `count` cycles; count 0 = run until `halt_req`. Mem-select ignored.
- Bad header (unknown cmd, LOAD mem select >= NUM_MEMS, LOAD count 0): set `err`, consume the word, stay IDLE.
- FSM: IDLE -(LOAD hdr)-> ADDR -(addr word)-> DATA -(last word)-> IDLE; IDLE -(RUN hdr)-> RUN -(counter expires or halt_req)-> IDLE.
- `s_ready`=1 in IDLE, ADDR, DATA; 0 in RUN. No backpressure from BRAM: one word per cycle sustained.
- Reset values: `s_ready`=0 during rst, 1 first cycle after; `w_enb`=0, `w_addr`=0, `w_dat`=0, `cpu_stall`=1, `busy`=0, `load_done`=0, `run_done`=0, `err`=0.
- `rst` mid-LOAD/RUN: abort immediately, no further writes, `cpu_stall`=1, no done pulse.

## Timing
- All outputs registered.
- Data word accepted in cycle t -> `w_enb[sel]`, `w_addr`, `w_dat` valid in cycle t+1 for exactly one cycle.
- `load_done` pulses in the same cycle as the last `w_enb`.
- RUN header accepted in cycle t -> `cpu_stall`=0 in cycles t+1 .. t+count; `cpu_stall`=1 and `run_done`=1 in cycle t+count+1.
- `halt_req` sampled high in cycle u during RUN -> `cpu_stall`=1, `run_done`=1 in u+1. Coincides with counter expiry: single `run_done`.
- Back-to-back frames: a new header may be accepted the cycle after the last data word or the cycle after `run_done`.

## Structure
- Shared package/include (`rv32i_params.vh`): cmd codes `LDR_CMD_LOAD`, `LDR_CMD_RUN`, memory index constants `LDR_MEM_INSTR`=0, `LDR_MEM_DATA`=1, state encodings.
- 16-bit down-counter shared by DATA word count and RUN cycle count; 2-bit state register; no sub-module required, optional `ldr_hdr_decode` combinational decoder.

## Test plan
- LOAD mem 0, base 0x000, 7 words -> `w_enb[0]` on 7 consecutive cycles at 0x000..0x018, `load_done` with 7th write, `w_enb[1]` never high.
- LOAD mem 1, base 0x3FC, 3 words -> writes at 0x3FC, 0x000, 0x004 (wrap).
- RUN count 7 after loading slti program -> `cpu_stall` low exactly 7 cycles; core x5=0x5, x6=0x1.
- RUN count 0, `halt_req` after 20 cycles -> stall low 20 cycles, `run_done` next cycle, `s_ready` low throughout.
- Header 0x01_05_0004 (mem 5) and cmd 0x7F -> `err`=1, no writes, next valid LOAD proceeds normally.
- `rst` asserted during DATA word 3 of 6 -> no further `w_enb`, `cpu_stall`=1, `load_done` never pulses, `err`=0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared constants and types for the program/data loader: command codes,
// memory indices and the loader state encoding.
package prog_loader_pkg;

  localparam logic [7:0] LDR_CMD_LOAD = 8'h01;
  localparam logic [7:0] LDR_CMD_RUN  = 8'h02;

  localparam int LDR_MEM_INSTR = 0;
  localparam int LDR_MEM_DATA  = 1;

  localparam int CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RUN  = 2'd3
  } ldr_state_e;

  // Width of a memory-select index; at least one bit even for a single target.
  function automatic int sel_width(input int num_mems);
    return (num_mems > 1) ? $clog2(num_mems) : 1;
  endfunction

endpackage

// File: rtl/prog_loader_hdr_decode.sv
// Combinational header decoder: splits a frame header into command fields
// and classifies it as a valid LOAD, a RUN, or a malformed header.
module prog_loader_hdr_decode
  import prog_loader_pkg::*;
#(
  parameter int NUM_MEMS = 2,
  parameter int SEL_W    = 1
) (
  input  logic [31:0]          hdr,
  output logic                 is_load,
  output logic                 is_run,
  output logic                 bad,
  output logic [SEL_W-1:0]     sel,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [7:0] MEM_LIMIT = 8'(NUM_MEMS);

  logic [7:0] cmd;
  logic [7:0] mem;

  assign cmd   = hdr[31:24];
  assign mem   = hdr[23:16];
  assign count = hdr[15:0];
  assign sel   = hdr[16 +: SEL_W];

  // A zero-length LOAD is rejected rather than treated as a no-op frame.
  assign is_load = (cmd == LDR_CMD_LOAD) && (mem < MEM_LIMIT) && (count != '0);
  assign is_run  = (cmd == LDR_CMD_RUN);
  assign bad     = !is_load && !is_run;

endmodule

// File: rtl/prog_loader.sv
// Framed word-stream loader: writes LOAD payloads into one of NUM_MEMS BRAM
// write ports, then releases the core's PC stall for a RUN window.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_MEMS   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  input  logic [DATA_WIDTH-1:0]          s_data,
  output logic                           s_ready,
  input  logic                           halt_req,
  output logic [NUM_MEMS*ADDR_WIDTH-1:0] w_addr,
  output logic [NUM_MEMS*DATA_WIDTH-1:0] w_dat,
  output logic [NUM_MEMS-1:0]            w_enb,
  output logic                           cpu_stall,
  output logic                           busy,
  output logic                           load_done,
  output logic                           run_done,
  output logic                           err
);

  localparam int SEL_W = sel_width(NUM_MEMS);

  ldr_state_e           state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [SEL_W-1:0]     sel_reg, sel_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic stall_reg, stall_next;
  logic err_reg, err_next;
  logic ready_reg, ready_next;
  logic load_done_reg, load_done_next;
  logic run_done_reg, run_done_next;
  logic wr_fire;
  logic accept;

  logic                 dec_is_load, dec_is_run, dec_bad;
  logic [SEL_W-1:0]     dec_sel;
  logic [CNT_WIDTH-1:0] dec_count;

  prog_loader_hdr_decode #(
    .NUM_MEMS (NUM_MEMS),
    .SEL_W    (SEL_W)
  ) u_hdr_decode (
    .hdr     (s_data[31:0]),
    .is_load (dec_is_load),
    .is_run  (dec_is_run),
    .bad     (dec_bad),
    .sel     (dec_sel),
    .count   (dec_count)
  );

  assign accept = s_valid && ready_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      sel_reg       <= '0;
      addr_reg      <= '0;
      stall_reg     <= 1'b1;
      err_reg       <= 1'b0;
      ready_reg     <= 1'b0;
      load_done_reg <= 1'b0;
      run_done_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      sel_reg       <= sel_next;
      addr_reg      <= addr_next;
      stall_reg     <= stall_next;
      err_reg       <= err_next;
      ready_reg     <= ready_next;
      load_done_reg <= load_done_next;
      run_done_reg  <= run_done_next;
    end
  end

  // One counter serves both the remaining LOAD words and the RUN cycles;
  // a RUN loaded with zero never decrements and so only ends on halt_req.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    sel_next       = sel_reg;
    addr_next      = addr_reg;
    stall_next     = stall_reg;
    err_next       = err_reg;
    load_done_next = 1'b0;
    run_done_next  = 1'b0;
    wr_fire        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (dec_is_load) begin
            state_next = ST_ADDR;
            cnt_next   = dec_count;
            sel_next   = dec_sel;
          end else if (dec_is_run) begin
            state_next = ST_RUN;
            cnt_next   = dec_count;
            stall_next = 1'b0;
          end else if (dec_bad) begin
            err_next = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (accept) begin
          addr_next  = s_data[ADDR_WIDTH-1:0];
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          wr_fire   = 1'b1;
          addr_next = addr_reg + ADDR_WIDTH'(4);
          cnt_next  = cnt_reg - 1'b1;
          if (cnt_reg == CNT_WIDTH'(1)) begin
            load_done_next = 1'b1;
            state_next     = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        if (halt_req || cnt_reg == CNT_WIDTH'(1)) begin
          state_next    = ST_IDLE;
          stall_next    = 1'b1;
          run_done_next = 1'b1;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    ready_next = (state_next != ST_RUN);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MEMS; gi++) begin : g_port
      logic [ADDR_WIDTH-1:0] port_addr_reg;
      logic [DATA_WIDTH-1:0] port_dat_reg;
      logic                  port_enb_reg;
      logic                  hit;

      assign hit = wr_fire && (sel_reg == SEL_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          port_addr_reg <= '0;
          port_dat_reg  <= '0;
          port_enb_reg  <= 1'b0;
        end else begin
          port_enb_reg <= hit;
          if (hit) begin
            port_addr_reg <= addr_reg;
            port_dat_reg  <= s_data;
          end
        end
      end

      assign w_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] = port_addr_reg;
      assign w_dat[gi*DATA_WIDTH +: DATA_WIDTH]  = port_dat_reg;
      assign w_enb[gi]                           = port_enb_reg;
    end
  endgenerate

  assign s_ready   = ready_reg;
  assign cpu_stall = stall_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign load_done = load_done_reg;
  assign run_done  = run_done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a frame-level model predicts writes and
// RUN windows by cycle; a negedge process compares every output each cycle.
module tb_prog_loader;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int NM  = 2;
  localparam int INF = 32'h3fff_ffff;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid;
  logic [DW-1:0]  s_data;
  logic           s_ready;
  logic           halt_req;
  logic [NM*AW-1:0] w_addr;
  logic [NM*DW-1:0] w_dat;
  logic [NM-1:0]  w_enb;
  logic           cpu_stall, busy, load_done, run_done, err;

  prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_MEMS(NM)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .halt_req(halt_req), .w_addr(w_addr), .w_dat(w_dat), .w_enb(w_enb),
    .cpu_stall(cpu_stall), .busy(busy), .load_done(load_done),
    .run_done(run_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: expected writes with the cycle they must appear in,
  // plus the busy/RUN windows and the cycle err must rise.
  typedef struct {
    int cyc;
    int mem;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit last;
  } wr_t;

  wr_t exp_q[$];
  int  obs_mem[$];
  int  obs_addr[$];
  int  m_phase, m_mem, m_cnt, m_idx;
  logic [AW-1:0] m_base;
  int  run_start, run_end, load_start, load_end, err_from;
  int  stall_low, ld_pulses, rd_pulses;
  bit  chk_en = 1'b0;

  task automatic model_reset();
    exp_q.delete();
    m_phase = 0;
    run_start = INF; run_end = INF;
    load_start = INF; load_end = INF;
    err_from = INF;
  endtask

  task automatic model_accept(input logic [DW-1:0] w, input int c);
    wr_t e;
    case (m_phase)
      0: begin
        if (w[31:24] == 8'h01 && w[23:16] < 8'(NM) && w[15:0] != 16'd0) begin
          m_phase = 1; m_mem = int'(w[23:16]); m_cnt = int'(w[15:0]); m_idx = 0;
          load_start = c + 1; load_end = INF;
        end else if (w[31:24] == 8'h02) begin
          run_start = c + 1;
          run_end   = (w[15:0] == 16'd0) ? INF : c + int'(w[15:0]) + 1;
        end else if (err_from == INF) begin
          err_from = c + 1;
        end
      end
      1: begin
        m_base  = w[AW-1:0];
        m_phase = 2;
      end
      default: begin
        e.cyc  = c + 1;
        e.mem  = m_mem;
        e.addr = AW'((int'(m_base) + 4 * m_idx) % (1 << AW));
        e.data = w;
        e.last = (m_idx == m_cnt - 1);
        exp_q.push_back(e);
        m_idx++;
        if (e.last) begin
          m_phase  = 0;
          load_end = c + 1;
        end
      end
    endcase
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NM-1:0] exp_enb;
      logic          exp_ld;
      bit            in_run, in_load;
      wr_t           e;
      exp_enb = '0;
      exp_ld  = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.cyc == cyc) begin
          exp_enb = NM'(1) << e.mem;
          exp_ld  = e.last;
          chk("w_addr", 64'(w_addr[e.mem*AW +: AW]), 64'(e.addr));
          chk("w_dat", 64'(w_dat[e.mem*DW +: DW]), 64'(e.data));
        end
      end
      chk("w_enb", 64'(w_enb), 64'(exp_enb));
      chk("load_done", 64'(load_done), 64'(exp_ld));
      in_run  = (cyc >= run_start) && (cyc < run_end);
      in_load = (cyc >= load_start) && (cyc < load_end);
      chk("cpu_stall", 64'(cpu_stall), 64'(!in_run));
      chk("run_done", 64'(run_done), 64'(cyc == run_end));
      chk("s_ready", 64'(s_ready), 64'(!in_run));
      chk("busy", 64'(busy), 64'(in_run || in_load));
      chk("err", 64'(err), 64'(cyc >= err_from));
      if (w_enb != '0) begin
        obs_mem.push_back(w_enb[1] ? 1 : 0);
        obs_addr.push_back(int'(w_enb[1] ? w_addr[AW +: AW] : w_addr[0 +: AW]));
      end
      if (!cpu_stall) stall_low++;
      if (load_done) ld_pulses++;
      if (run_done) rd_pulses++;
    end
  end

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic send(input logic [DW-1:0] w);
    int waitc = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && waitc < 200) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!s_ready) begin
      chk("send_timeout", 64'(s_ready), 64'(1));
    end else begin
      $display("tx cycle=%0d word=0x%08h", cyc, w);
      model_accept(w, cyc);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b0;
    model_reset();
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_w_enb", 64'(w_enb), 64'(0));
    chk("rst_w_addr", 64'(w_addr), 64'(0));
    chk("rst_w_dat", 64'(w_dat), 64'(0));
    chk("rst_cpu_stall", 64'(cpu_stall), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'({load_done, run_done}), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    repeat (n - 1) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(s_ready), 64'(1));
    chk_en = 1'b1;
  endtask

  task automatic wait_run_done(input int rd0);
    int n = 0;
    while (rd_pulses == rd0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("run_done_seen", 64'(rd_pulses - rd0), 64'(1));
  endtask

  initial begin
    int sl0, rd0;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; halt_req = 1'b0;
    stall_low = 0; ld_pulses = 0; rd_pulses = 0;
    model_reset();
    do_reset(2);

    // LOAD mem 0, base 0, seven words (a short slti program image).
    send(32'h0100_0007);
    send(32'h0000_0000);
    send(32'h0050_0293); send(32'h0002_a313); send(32'h0063_2313);
    send(32'h0010_0393); send(32'h0000_0013); send(32'h0000_0013);
    send(32'h0000_006f);
    @(posedge clk); #1;
    chk("l0_count", 64'(obs_addr.size()), 64'(7));
    chk("l0_first_addr", 64'(obs_addr[0]), 64'(0));
    chk("l0_last_addr", 64'(obs_addr[6]), 64'(32'h018));
    chk("l0_mem", 64'(obs_mem[6]), 64'(0));
    chk("l0_load_done", 64'(ld_pulses), 64'(1));

    // LOAD mem 1 at the top of the address space: wraps to 0.
    send(32'h0101_0003);
    send(32'h0000_03fc);
    send(32'hdead_0001); send(32'hdead_0002); send(32'hdead_0003);
    @(posedge clk); #1;
    chk("l1_addr0", 64'(obs_addr[7]), 64'(32'h3fc));
    chk("l1_addr1", 64'(obs_addr[8]), 64'(32'h000));
    chk("l1_addr2", 64'(obs_addr[9]), 64'(32'h004));
    chk("l1_mem", 64'(obs_mem[8]), 64'(1));
    chk("l1_load_done", 64'(ld_pulses), 64'(2));

    // RUN for 7 cycles.
    sl0 = stall_low; rd0 = rd_pulses;
    send(32'h02ff_0007);
    wait_run_done(rd0);
    chk("run7_low_cycles", 64'(stall_low - sl0), 64'(7));

    // Open-ended RUN stopped by halt_req after 20 released cycles.
    sl0 = stall_low; rd0 = rd_pulses;
    send(32'h0200_0000);
    repeat (19) begin @(posedge clk); #1; end
    halt_req = 1'b1;
    run_end  = cyc + 1;
    @(posedge clk); #1;
    halt_req = 1'b0;
    wait_run_done(rd0);
    chk("run0_low_cycles", 64'(stall_low - sl0), 64'(20));

    // Malformed headers set err; a following LOAD still works.
    send(32'h0105_0004);
    send(32'h7f00_0001);
    send(32'h0100_0000);
    @(posedge clk); #1;
    chk("bad_err", 64'(err), 64'(1));
    chk("bad_no_writes", 64'(obs_addr.size()), 64'(10));
    send(32'h0100_0002);
    send(32'h0000_0100);
    send(32'h1111_1111); send(32'h2222_2222);
    @(posedge clk); #1;
    chk("after_bad_addr0", 64'(obs_addr[10]), 64'(32'h100));
    chk("after_bad_addr1", 64'(obs_addr[11]), 64'(32'h104));

    // Reset in place of the third of six data words.
    send(32'h0101_0006);
    send(32'h0000_0040);
    send(32'haaaa_0001); send(32'haaaa_0002);
    do_reset(3);
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_writes", 64'(obs_addr.size()), 64'(14));
    chk("abort_last_addr", 64'(obs_addr[13]), 64'(32'h044));
    chk("abort_load_done", 64'(ld_pulses), 64'(3));
    chk("abort_err", 64'(err), 64'(0));

    // Recovery LOAD after the abort.
    send(32'h0101_0002);
    send(32'h0000_03f8);
    send(32'h5555_0001); send(32'h5555_0002);
    @(posedge clk); #1;
    chk("recover_addr", 64'(obs_addr[15]), 64'(32'h3fc));
    chk("recover_load_done", 64'(ld_pulses), 64'(4));

    repeat (3) begin @(posedge clk); #1; end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
